// File: rtl/cv32e40p_x_if_pkg.sv
// Shared types for the out-of-order X-interface dispatcher.
package cv32e40p_x_if_pkg;

    // IDs are stored zero-extended to this width inside the in-flight table,
    // so X_ID_WIDTH must not exceed it.
    localparam int unsigned X_INFLIGHT_ID_W = 8;

    typedef enum logic [1:0] {
        READ  = 2'b00,
        WRITE = 2'b01
    } mem_req_type_e;

    // One outstanding coprocessor writeback.
    typedef struct packed {
        logic                       valid;
        logic [X_INFLIGHT_ID_W-1:0] id;
        logic [4:0]                 rd;
    } x_inflight_t;

endpackage

// File: rtl/cv32e40p_x_inflight_table.sv
// Table of outstanding coprocessor writebacks; the register scoreboard is
// derived from it combinationally.
module cv32e40p_x_inflight_table
    import cv32e40p_x_if_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_i,
    input  logic [ID_WIDTH-1:0] alloc_id_i,
    input  logic [4:0]          alloc_rd_i,
    input  logic                retire_i,
    input  logic [ID_WIDTH-1:0] retire_id_i,
    input  logic [ID_WIDTH-1:0] query_id_i,
    input  logic [4:0]          query_rd_i,
    output logic                full_o,
    output logic                id_busy_o,
    output logic                rd_last_retire_o,
    output logic [31:0]         sb_o
);

    x_inflight_t [DEPTH-1:0] entries_q, entries_d;
    logic                    alloc_found;
    logic                    holder_retiring;
    logic                    holder_other;

    // Retire by ID, then allocate the lowest slot that was free last cycle
    // (a slot freed this cycle only becomes allocatable next cycle).
    always_comb begin
        entries_d   = entries_q;
        alloc_found = 1'b0;
        if (retire_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].valid && entries_q[i].id == X_INFLIGHT_ID_W'(retire_id_i)) begin
                    entries_d[i].valid = 1'b0;
                end
            end
        end
        if (alloc_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!alloc_found && !entries_q[i].valid) begin
                    entries_d[i].valid = 1'b1;
                    entries_d[i].id    = X_INFLIGHT_ID_W'(alloc_id_i);
                    entries_d[i].rd    = alloc_rd_i;
                    alloc_found        = 1'b1;
                end
            end
        end
    end

    // Table state register; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    // Status from registered state: full, ID in use, scoreboard, and whether
    // this cycle's result retires the last writer of the queried rd.
    always_comb begin
        full_o          = 1'b1;
        id_busy_o       = 1'b0;
        sb_o            = '0;
        holder_retiring = 1'b0;
        holder_other    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!entries_q[i].valid) begin
                full_o = 1'b0;
            end else begin
                if (entries_q[i].id == X_INFLIGHT_ID_W'(query_id_i)) begin
                    id_busy_o = 1'b1;
                end
                sb_o[entries_q[i].rd] = 1'b1;
                if (entries_q[i].rd == query_rd_i) begin
                    if (retire_i && entries_q[i].id == X_INFLIGHT_ID_W'(retire_id_i)) begin
                        holder_retiring = 1'b1;
                    end else begin
                        holder_other = 1'b1;
                    end
                end
            end
        end
        rd_last_retire_o = holder_retiring & ~holder_other;
    end

endmodule

// File: rtl/cv32e40p_x_disp_ooo.sv
// X-interface dispatcher with ID-tagged out-of-order result tracking,
// memory-op counter and xmem glue.
module cv32e40p_x_disp_ooo
    import cv32e40p_x_if_pkg::*;
#(
    parameter int X_NUM_RS          = 3,
    parameter int X_ID_WIDTH        = 4,
    parameter int X_MAX_OUTSTANDING = 4,
    parameter int X_MEM_CNT_WIDTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     x_illegal_insn_dec_i,
    input  logic                     x_branch_or_jump_i,
    input  logic                     x_data_req_dec_i,
    input  logic                     id_ready_i,
    input  logic [4:0]               x_waddr_id_i,
    input  logic                     x_writeback_i,
    input  logic [4:0]               x_waddr_ex_i,
    input  logic [4:0]               x_waddr_wb_i,
    input  logic                     x_we_ex_i,
    input  logic                     x_we_wb_i,
    input  logic [X_NUM_RS-1:0][4:0] x_rs_addr_i,
    input  logic [X_NUM_RS-1:0]      x_regs_used_i,
    output logic                     x_valid_o,
    input  logic                     x_ready_i,
    input  logic                     x_accept_i,
    input  logic                     x_is_mem_op_i,
    output logic [X_ID_WIDTH-1:0]    x_id_o,
    output logic [X_NUM_RS-1:0]      x_rs_valid_o,
    output logic                     x_rd_clean_o,
    output logic                     x_stall_o,
    output logic                     x_illegal_insn_o,
    input  logic                     x_rvalid_i,
    input  logic [X_ID_WIDTH-1:0]    x_rid_i,
    input  logic [4:0]               x_rwaddr_i,
    output logic                     x_rready_o,
    input  logic                     xmem_valid_i,
    input  logic                     xmem_endoftransaction_i,
    input  logic                     xmem_rready_i,
    input  logic                     xmem_instr_wb_i,
    input  mem_req_type_e            xmem_req_type_i,
    output logic                     xmem_ready_o,
    output logic                     xmem_data_req_o,
    output logic                     xmem_we_o,
    output logic                     xmem_rvalid_o,
    output logic                     xmem_status_o
);

    logic [X_ID_WIDTH-1:0]      id_q, id_d;
    logic [X_MEM_CNT_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
    logic                       offloaded_q, offloaded_d;
    logic                       wb_done_q, wb_done_d;
    logic [31:0]                sb;
    logic                       full, id_busy, rd_last_retire;
    logic                       fire, accept, mem_full, mem_inc, dep;
    logic                       rd_ex_hit, rd_wb_hit;
    logic                       unused_inputs;

    // Result address and end-of-transaction carry nothing this block needs.
    assign unused_inputs = ^{x_rwaddr_i, xmem_endoftransaction_i};

    cv32e40p_x_inflight_table #(
        .DEPTH    (X_MAX_OUTSTANDING),
        .ID_WIDTH (X_ID_WIDTH)
    ) i_inflight_table (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .alloc_i          (accept & x_writeback_i),
        .alloc_id_i       (id_q),
        .alloc_rd_i       (x_waddr_id_i),
        .retire_i         (x_rvalid_i),
        .retire_id_i      (x_rid_i),
        .query_id_i       (id_q),
        .query_rd_i       (x_waddr_id_i),
        .full_o           (full),
        .id_busy_o        (id_busy),
        .rd_last_retire_o (rd_last_retire),
        .sb_o             (sb)
    );

    assign mem_full  = (mem_cnt_q == {X_MEM_CNT_WIDTH{1'b1}});
    assign x_valid_o = x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~offloaded_q & ~id_busy
                     & ~(full & x_writeback_i) & ~(mem_full & x_is_mem_op_i);
    assign fire      = x_valid_o & x_ready_i;
    assign accept    = fire & x_accept_i;
    assign mem_inc   = accept & x_is_mem_op_i;
    assign x_illegal_insn_o = fire & ~x_accept_i;
    assign x_id_o    = id_q;

    assign rd_ex_hit    = x_we_ex_i & (x_waddr_ex_i == x_waddr_id_i);
    assign rd_wb_hit    = x_we_wb_i & (x_waddr_wb_i == x_waddr_id_i);
    assign x_rd_clean_o = ~((sb[x_waddr_id_i] & ~rd_last_retire) | rd_ex_hit | rd_wb_hit);

    // Source operand readiness and the data dependency on in-flight results.
    always_comb begin
        x_rs_valid_o = '0;
        dep          = 1'b0;
        for (int i = 0; i < X_NUM_RS; i++) begin
            x_rs_valid_o[i] = ~(sb[x_rs_addr_i[i]]
                              | (x_we_ex_i & (x_waddr_ex_i == x_rs_addr_i[i]))
                              | (x_we_wb_i & (x_waddr_wb_i == x_rs_addr_i[i])));
            dep = dep | (x_regs_used_i[i] & sb[x_rs_addr_i[i]]);
        end
        dep = dep & ~x_illegal_insn_o;
    end

    assign x_stall_o = (x_valid_o & ~x_ready_i) | dep | (x_data_req_dec_i & (mem_cnt_q != '0))
                     | (x_illegal_insn_dec_i & (x_branch_or_jump_i | full | id_busy | mem_full))
                     | (xmem_valid_i & ~fire);

    assign xmem_ready_o    = xmem_valid_i;
    assign xmem_data_req_o = xmem_valid_i;
    assign xmem_we_o       = xmem_valid_i & (xmem_req_type_i == WRITE);
    assign xmem_rvalid_o   = xmem_instr_wb_i & ~wb_done_q;
    assign xmem_status_o   = 1'b1;
    assign x_rready_o      = 1'b1;

    // Next-state for the ID counter, memory-op counter and handshake flags.
    always_comb begin
        id_d        = id_q;
        mem_cnt_d   = mem_cnt_q;
        offloaded_d = offloaded_q;
        wb_done_d   = wb_done_q;
        if (accept) begin
            id_d = id_q + X_ID_WIDTH'(1);
        end
        case ({mem_inc, xmem_valid_i})
            2'b10:   mem_cnt_d = mem_cnt_q + X_MEM_CNT_WIDTH'(1);
            2'b01:   if (mem_cnt_q != '0) mem_cnt_d = mem_cnt_q - X_MEM_CNT_WIDTH'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase
        if (id_ready_i) begin
            offloaded_d = 1'b0;
        end else if (fire) begin
            offloaded_d = 1'b1;
        end
        if (xmem_valid_i) begin
            wb_done_d = 1'b0;
        end else if (xmem_rvalid_o & xmem_rready_i) begin
            wb_done_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q        <= '0;
            mem_cnt_q   <= '0;
            offloaded_q <= 1'b0;
            wb_done_q   <= 1'b0;
        end else begin
            id_q        <= id_d;
            mem_cnt_q   <= mem_cnt_d;
            offloaded_q <= offloaded_d;
            wb_done_q   <= wb_done_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_disp_ooo.sv
// Self-checking bench for cv32e40p_x_disp_ooo: vector table plus scoreboard
// queue, with hand-written sequences for memory-counter, xmem and reset cases.
module tb_cv32e40p_x_disp_ooo;
    import cv32e40p_x_if_pkg::*;

    localparam int NRS = 3;
    localparam int IDW = 4;

    logic                clk, rst_n;
    logic                ill_dec, bj, data_req_dec, id_ready;
    logic [4:0]          waddr_id, waddr_ex, waddr_wb;
    logic                writeback, we_ex, we_wb;
    logic [NRS-1:0][4:0] rs_addr;
    logic [NRS-1:0]      regs_used;
    logic                x_valid, x_ready, x_accept, x_is_mem_op;
    logic [IDW-1:0]      x_id;
    logic [NRS-1:0]      rs_valid;
    logic                rd_clean, stall, illegal_o;
    logic                rvalid, rready;
    logic [IDW-1:0]      rid;
    logic [4:0]          rwaddr;
    logic                xmem_valid, xmem_eot, xmem_rready, xmem_instr_wb;
    mem_req_type_e       xmem_type;
    logic                xmem_ready, xmem_data_req, xmem_we, xmem_rvalid, xmem_status;

    cv32e40p_x_disp_ooo #(
        .X_NUM_RS(NRS), .X_ID_WIDTH(IDW), .X_MAX_OUTSTANDING(4), .X_MEM_CNT_WIDTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .x_illegal_insn_dec_i(ill_dec), .x_branch_or_jump_i(bj),
        .x_data_req_dec_i(data_req_dec), .id_ready_i(id_ready),
        .x_waddr_id_i(waddr_id), .x_writeback_i(writeback),
        .x_waddr_ex_i(waddr_ex), .x_waddr_wb_i(waddr_wb),
        .x_we_ex_i(we_ex), .x_we_wb_i(we_wb),
        .x_rs_addr_i(rs_addr), .x_regs_used_i(regs_used),
        .x_valid_o(x_valid), .x_ready_i(x_ready), .x_accept_i(x_accept),
        .x_is_mem_op_i(x_is_mem_op), .x_id_o(x_id),
        .x_rs_valid_o(rs_valid), .x_rd_clean_o(rd_clean),
        .x_stall_o(stall), .x_illegal_insn_o(illegal_o),
        .x_rvalid_i(rvalid), .x_rid_i(rid), .x_rwaddr_i(rwaddr), .x_rready_o(rready),
        .xmem_valid_i(xmem_valid), .xmem_endoftransaction_i(xmem_eot),
        .xmem_rready_i(xmem_rready), .xmem_instr_wb_i(xmem_instr_wb),
        .xmem_req_type_i(xmem_type),
        .xmem_ready_o(xmem_ready), .xmem_data_req_o(xmem_data_req), .xmem_we_o(xmem_we),
        .xmem_rvalid_o(xmem_rvalid), .xmem_status_o(xmem_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ill, bj, wb;
        logic [4:0] rd;
        logic       rdy, acc, mem, rv;
        logic [3:0] rid;
        logic       dreq, xv, idr;
        logic [4:0] rs;
        logic       used;
        logic       e_valid;
        logic [3:0] e_id;
        logic       e_ill, e_stall, e_rsv, e_rdc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    function automatic vec_t mk(input logic ill, input logic bj_i, input logic wb,
                                input logic [4:0] rd, input logic rdy, input logic acc,
                                input logic mem, input logic rv, input logic [3:0] rid_i,
                                input logic dreq, input logic xv, input logic idr,
                                input logic [4:0] rs, input logic used,
                                input logic e_valid, input logic [3:0] e_id, input logic e_ill,
                                input logic e_stall, input logic e_rsv, input logic e_rdc);
        vec_t v;
        v.ill = ill; v.bj = bj_i; v.wb = wb; v.rd = rd; v.rdy = rdy; v.acc = acc;
        v.mem = mem; v.rv = rv; v.rid = rid_i; v.dreq = dreq; v.xv = xv; v.idr = idr;
        v.rs = rs; v.used = used;
        v.e_valid = e_valid; v.e_id = e_id; v.e_ill = e_ill;
        v.e_stall = e_stall; v.e_rsv = e_rsv; v.e_rdc = e_rdc;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs they must produce.
    task automatic applyStimulus(input vec_t v);
        ill_dec = v.ill; bj = v.bj; writeback = v.wb; waddr_id = v.rd;
        x_ready = v.rdy; x_accept = v.acc; x_is_mem_op = v.mem;
        rvalid = v.rv; rid = v.rid; data_req_dec = v.dreq; xmem_valid = v.xv;
        id_ready = v.idr; rs_addr[0] = v.rs; regs_used = {2'b00, v.used};
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic checkOutput(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL %s: no expectation queued", tag);
        end else begin
            e = exp_q.pop_front();
            checkValue({tag, " x_valid"},   x_valid,     e.e_valid);
            checkValue({tag, " x_id"},      x_id,        e.e_id);
            checkValue({tag, " illegal"},   illegal_o,   e.e_ill);
            checkValue({tag, " stall"},     stall,       e.e_stall);
            checkValue({tag, " rs_valid0"}, rs_valid[0], e.e_rsv);
            checkValue({tag, " rd_clean"},  rd_clean,    e.e_rdc);
        end
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ill_dec = 0; bj = 0; data_req_dec = 0; id_ready = 0; waddr_id = 0; writeback = 0;
        waddr_ex = 0; waddr_wb = 0; we_ex = 0; we_wb = 0; rs_addr = '0; regs_used = '0;
        x_ready = 0; x_accept = 0; x_is_mem_op = 0; rvalid = 0; rid = 0; rwaddr = 0;
        xmem_valid = 0; xmem_eot = 0; xmem_rready = 0; xmem_instr_wb = 0; xmem_type = READ;

        // ill rd.. columns: ill bj wb rd rdy acc mem rv rid dreq xv idr rs used | expected
        vecs.push_back(mk(0,0,0, 5,0,0,0,0, 0,0,0,1, 5,0, 0, 0,0,0,1,1));
        vecs.push_back(mk(1,0,1, 5,1,1,0,0, 0,0,0,1, 5,0, 1, 0,0,0,1,1));
        vecs.push_back(mk(0,0,0, 5,0,0,0,0, 0,0,0,1, 5,0, 0, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 5,0,0,0,1, 0,0,0,1, 5,0, 0, 1,0,0,0,1));
        vecs.push_back(mk(0,0,0, 5,0,0,0,0, 0,0,0,1, 5,0, 0, 1,0,0,1,1));
        vecs.push_back(mk(1,0,1, 7,1,1,0,0, 0,0,0,1, 7,0, 1, 1,0,0,1,1));
        vecs.push_back(mk(1,0,1, 7,1,1,0,0, 0,0,0,1, 7,0, 1, 2,0,0,0,0));
        vecs.push_back(mk(0,0,0, 7,0,0,0,1, 1,0,0,1, 7,0, 0, 3,0,0,0,0));
        vecs.push_back(mk(0,0,0, 7,0,0,0,0, 0,0,0,1, 7,0, 0, 3,0,0,0,0));
        vecs.push_back(mk(0,0,0, 7,0,0,0,1, 2,0,0,1, 7,0, 0, 3,0,0,0,1));
        vecs.push_back(mk(0,0,0, 7,0,0,0,0, 0,0,0,1, 7,0, 0, 3,0,0,1,1));
        vecs.push_back(mk(1,0,1,10,1,1,0,0, 0,0,0,1, 1,0, 1, 3,0,0,1,1));
        vecs.push_back(mk(1,0,1,11,1,1,0,0, 0,0,0,1, 1,0, 1, 4,0,0,1,1));
        vecs.push_back(mk(1,0,1,12,1,1,0,0, 0,0,0,1, 1,0, 1, 5,0,0,1,1));
        vecs.push_back(mk(1,0,1,13,1,1,0,0, 0,0,0,1, 1,0, 1, 6,0,0,1,1));
        vecs.push_back(mk(1,0,1,14,1,1,0,0, 0,0,0,1, 1,0, 0, 7,0,1,1,1));
        vecs.push_back(mk(1,0,1,14,1,1,0,1, 3,0,0,1, 1,0, 0, 7,0,1,1,1));
        vecs.push_back(mk(1,0,1,14,1,1,0,0, 0,0,0,1, 1,0, 1, 7,0,0,1,1));
        vecs.push_back(mk(0,0,0,11,0,0,0,1, 4,0,0,1,11,0, 0, 8,0,0,0,1));
        vecs.push_back(mk(0,0,0,12,0,0,0,1, 5,0,0,1,12,0, 0, 8,0,0,0,1));
        vecs.push_back(mk(0,0,0,13,0,0,0,1, 6,0,0,1,13,0, 0, 8,0,0,0,1));
        vecs.push_back(mk(0,0,0,14,0,0,0,1, 7,0,0,1,14,0, 0, 8,0,0,0,1));
        vecs.push_back(mk(1,0,1,20,1,0,0,0, 0,0,0,1,20,0, 1, 8,1,0,1,1));
        vecs.push_back(mk(0,0,0,20,0,0,0,0, 0,0,0,1,20,0, 0, 8,0,0,1,1));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 1, 8,0,1,1,1));
        vecs.push_back(mk(1,0,0, 0,1,1,0,0, 0,0,0,0, 0,0, 1, 8,0,0,1,1));
        vecs.push_back(mk(1,0,0, 0,1,1,0,0, 0,0,0,0, 0,0, 0, 9,0,0,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,1, 0,0, 0, 9,0,0,1,1));
        vecs.push_back(mk(1,1,0, 0,1,1,0,0, 0,0,0,1, 0,0, 0, 9,0,1,1,1));
        vecs.push_back(mk(1,0,1, 3,1,1,0,0, 0,0,0,1, 0,0, 1, 9,0,0,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,1,15,0,0,1, 3,1, 0,10,0,1,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,1, 3,1, 0,10,0,1,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,1, 9,0,0,1, 3,0, 0,10,0,0,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,1, 3,0, 0,10,0,0,1,1));
        vecs.push_back(mk(1,0,0, 0,1,1,1,0, 0,0,0,1, 0,0, 1,10,0,0,1,1));
        vecs.push_back(mk(1,0,0, 0,1,1,1,0, 0,0,0,1, 0,0, 1,11,0,0,1,1));
        vecs.push_back(mk(1,0,0, 0,1,1,1,0, 0,0,0,1, 0,0, 1,12,0,0,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,0,1, 0,0, 0,13,0,1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,1,1, 0,0, 0,13,0,1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,1,1, 0,0, 0,13,0,1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,1,1, 0,0, 0,13,0,1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,0,1, 0,0, 0,13,0,0,1,1));
        vecs.push_back(mk(1,0,0, 0,1,1,1,0, 0,0,1,1, 0,0, 1,13,0,0,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,0,1, 0,0, 0,14,0,0,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,1,1, 0,0, 0,14,0,1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,0,1, 0,0, 0,14,0,0,1,1));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset x_valid",  x_valid,  1'b0);
        checkValue("reset x_id",     x_id,     4'd0);
        checkValue("reset stall",    stall,    1'b0);
        checkValue("reset rs_valid", rs_valid, 3'b111);
        checkValue("reset rd_clean", rd_clean, 1'b1);
        rst_n = 1'b1;
        nextCycle();

        foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

        // Fill the memory-op counter to its maximum; IDs wrap modulo 16.
        for (int k = 0; k < 15; k++)
            runVec(mk(1,0,0,0,1,1,1,0,0,0,0,1,0,0, 1,4'(14 + k),0,0,1,1), $sformatf("memfill%0d", k));
        runVec(mk(1,0,0,0,1,1,1,0,0,0,0,1,0,0, 0,13,0,1,1,1), "memfull_block");
        for (int k = 0; k < 15; k++)
            runVec(mk(0,0,0,0,0,0,0,0,0,1,1,1,0,0, 0,13,0,1,1,1), $sformatf("memdrain%0d", k));
        runVec(mk(0,0,0,0,0,0,0,0,0,1,0,1,0,0, 0,13,0,0,1,1), "memdrained");

        // xmem request glue.
        xmem_valid = 1'b1; xmem_type = WRITE; data_req_dec = 1'b0;
        @(negedge clk);
        checkValue("xmem ready",    xmem_ready,    1'b1);
        checkValue("xmem data_req", xmem_data_req, 1'b1);
        checkValue("xmem we write", xmem_we,       1'b1);
        checkValue("xmem status",   xmem_status,   1'b1);
        checkValue("x_rready",      rready,        1'b1);
        nextCycle();
        xmem_type = READ;
        @(negedge clk);
        checkValue("xmem we read",  xmem_we,       1'b0);
        nextCycle();
        xmem_valid = 1'b0;
        @(negedge clk);
        checkValue("xmem ready idle", xmem_ready,  1'b0);

        // xmem result handshake.
        nextCycle();
        xmem_instr_wb = 1'b1; xmem_rready = 1'b0;
        @(negedge clk);
        checkValue("xmem rvalid first", xmem_rvalid, 1'b1);
        nextCycle();
        xmem_rready = 1'b1;
        @(negedge clk);
        checkValue("xmem rvalid hs", xmem_rvalid, 1'b1);
        nextCycle();
        xmem_rready = 1'b0;
        @(negedge clk);
        checkValue("xmem rvalid done", xmem_rvalid, 1'b0);
        nextCycle();
        xmem_valid = 1'b1;
        @(negedge clk);
        checkValue("xmem rvalid clr cyc", xmem_rvalid, 1'b0);
        nextCycle();
        xmem_valid = 1'b0;
        @(negedge clk);
        checkValue("xmem rvalid again", xmem_rvalid, 1'b1);
        nextCycle();
        xmem_instr_wb = 1'b0;

        // Core-side EX/WB forwarding hazards.
        rs_addr[0] = 5'd9; waddr_id = 5'd9; we_ex = 1'b1; waddr_ex = 5'd9;
        @(negedge clk);
        checkValue("ex hit rs_valid", rs_valid[0], 1'b0);
        checkValue("ex hit rd_clean", rd_clean,    1'b0);
        nextCycle();
        we_ex = 1'b0; we_wb = 1'b1; waddr_wb = 5'd9;
        @(negedge clk);
        checkValue("wb hit rs_valid", rs_valid[0], 1'b0);
        checkValue("wb hit rd_clean", rd_clean,    1'b0);
        nextCycle();
        we_wb = 1'b0;

        // Asynchronous reset with a live entry.
        runVec(mk(1,0,1,5,1,1,0,0,0,0,0,1,5,0, 1,13,0,0,1,1), "pre_reset_issue");
        runVec(mk(0,0,0,5,0,0,0,0,0,0,0,1,5,0, 0,14,0,0,0,0), "pre_reset_busy");
        #1;
        rst_n = 1'b0;
        #1;
        checkValue("mid reset rs_valid", rs_valid[0], 1'b1);
        checkValue("mid reset rd_clean", rd_clean,    1'b1);
        checkValue("mid reset x_id",     x_id,        4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        // Stale result IDs after reset are ignored.
        runVec(mk(1,0,1,6,1,1,0,0, 0,0,0,1,6,0, 1,0,0,0,1,1), "post_reset_issue");
        runVec(mk(0,0,0,6,0,0,0,1,13,0,0,1,6,0, 0,1,0,0,0,0), "stale_rid");
        runVec(mk(0,0,0,6,0,0,0,0, 0,0,0,1,6,0, 0,1,0,0,0,0), "stale_ignored");
        runVec(mk(0,0,0,6,0,0,0,1, 0,0,0,1,6,0, 0,1,0,0,0,1), "real_rid");
        runVec(mk(0,0,0,6,0,0,0,0, 0,0,0,1,6,0, 0,1,0,0,1,1), "rd6_free");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL leftover: got %0d queued expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cv32e40p_x_disp_ooo.md
# cv32e40p_x_disp_ooo

Parametrised successor of the core's X-interface dispatcher: offloads illegal-decoded instructions to the coprocessor and tracks up to `X_MAX_OUTSTANDING` results in flight, each tagged with a transaction ID. The per-register scoreboard is derived from an in-flight table, so several outstanding writes to the same `rd` are supported. It also provides a bounded memory-op counter and the xmem request/response glue. It sits in the ID stage beside the decoder and drives the stall into the controller.

## Interface
- `X_NUM_RS`, 3: source operands per instruction (2 or 3).
- `X_ID_WIDTH`, 4: transaction ID width. Must satisfy `2**X_ID_WIDTH >= X_MAX_OUTSTANDING`.
- `X_MAX_OUTSTANDING`, 4: in-flight table depth (1..16).
- `X_MEM_CNT_WIDTH`, 4: width of the outstanding memory-op counter.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `x_illegal_insn_dec_i`, `x_branch_or_jump_i`, `x_data_req_dec_i`, `id_ready_i` in 1: decoder/ID status.
- `x_waddr_id_i` in 5, `x_writeback_i` in 1: `rd` of the candidate instruction, and whether it writes back.
- `x_waddr_ex_i`, `x_waddr_wb_i` in 5; `x_we_ex_i`, `x_we_wb_i` in 1: core-side writers in EX and WB.
- `x_rs_addr_i` in `X_NUM_RS`x5; `x_regs_used_i` in `X_NUM_RS`: source addresses and their use flags.
- `x_valid_o` out 1; `x_ready_i`, `x_accept_i`, `x_is_mem_op_i` in 1: issue handshake.
- `x_id_o` out `X_ID_WIDTH`: ID of the issuing instruction.
- `x_rs_valid_o` out `X_NUM_RS`; `x_rd_clean_o` out 1: operand status.
- `x_stall_o`, `x_illegal_insn_o` out 1.
- `x_rvalid_i` in 1, `x_rid_i` in `X_ID_WIDTH`, `x_rwaddr_i` in 5, `x_rready_o` out 1: result channel.
- `xmem_valid_i`, `xmem_endoftransaction_i`, `xmem_rready_i`, `xmem_instr_wb_i` in 1; `xmem_req_type_i` in `mem_req_type_e`.
- `xmem_ready_o`, `xmem_data_req_o`, `xmem_we_o`, `xmem_rvalid_o`, `xmem_status_o` out 1.

## Operation
- Issue fire is `x_valid_o & x_ready_i`. Accept is fire & `x_accept_i`. Reject is fire & ~`x_accept_i`; on reject, `x_illegal_insn_o` = 1 combinationally.
- ID counter `id_q`:
  - `x_id_o` = `id_q`.
  - Increments modulo 2^`X_ID_WIDTH` on every accept, and only on accept.
- `x_valid_o` = illegal_dec & ~branch_or_jump & ~offloaded_q & ~id_busy & ~(full & `x_writeback_i`).
  - id_busy: a valid table entry already holds `id_q`.
  - full: all `X_MAX_OUTSTANDING` entries are valid.
- In-flight table: per entry {valid, id, rd}.
  - An accept with `x_writeback_i` allocates the lowest free entry.
  - `x_rvalid_i` clears the valid entry whose id equals `x_rid_i`. A result with no matching id is ignored.
- Scoreboard bit r = OR over valid entries of (rd == r). A register therefore stays busy until its last outstanding writer returns. The scoreboard has no separate register.
- Offloaded flag `offloaded_q`: cleared on `id_ready_i` (priority); otherwise set on fire.
- `x_rs_valid_o[i]` = ~(sb[rs_i] | EX hit | WB hit).
- `x_rd_clean_o` = ~((sb[rd] & ~same-cycle retire of the only entry holding rd) | EX hit | WB hit).
- dep = ~`x_illegal_insn_o` & OR_i(`x_regs_used_i[i]` & sb[rs_i]).
- Memory counter `mem_cnt_q`:
  - +1 on accept & `x_is_mem_op_i`; -1 on `xmem_valid_i`; both in the same cycle leave it unchanged.
  - mem_full: `mem_cnt_q` is at its maximum. A mem-op accept is blocked (`x_valid_o` gated) while mem_full.
  - `xmem_valid_i` while the counter is 0 is an environment error: the counter holds.
- `x_stall_o` = (`x_valid_o` & ~`x_ready_i`) | dep | (`x_data_req_dec_i` & `mem_cnt_q` != 0) | (illegal_dec & (branch_or_jump | full | id_busy | mem_full)) | (`xmem_valid_i` & ~fire).
- xmem signals:
  - `xmem_ready_o` = `xmem_data_req_o` = `xmem_valid_i`.
  - `xmem_we_o` = `xmem_valid_i` & (type == WRITE).
  - `xmem_rvalid_o` = `xmem_instr_wb_i` & ~wb_done_q. wb_done_q is set on the `xmem_rvalid_o` & `xmem_rready_i` handshake and cleared on the next `xmem_valid_i`.
  - `xmem_status_o` = 1. `x_rready_o` = 1.

## Timing
- Reset values: all table entries invalid, `id_q` = 0, `mem_cnt_q` = 0, `offloaded_q` = 0, wb_done_q = 0.
  - Resulting outputs: `x_valid_o` follows its combinational equation; `x_rs_valid_o` and `x_rd_clean_o` are all-ones unless EX/WB hits; `x_stall_o` = 0 with idle inputs.
- A table update is visible in the scoreboard one cycle after the accept or retire.
- A same-cycle retire and accept may target the same `rd`: the new entry wins and the scoreboard bit stays set.
- A slot freed in cycle t becomes allocatable at t+1. full uses registered state.
- Reset mid-operation drops all in-flight state. Late results carrying stale IDs are ignored.

## Structure
- `cv32e40p_x_if_pkg` holds `mem_req_type_e` and a new `x_inflight_t` struct {valid, id, rd}.
- The in-flight table is the one natural sub-module: `cv32e40p_x_inflight_table`. It provides alloc/retire ports, full, id_busy and a 32-bit scoreboard output.

## Test plan
- Reset, then offload `rd`=5 with writeback and accept → `x_id_o` = 0, sb[5] = 1 next cycle. Result with `x_rid_i` = 0 → sb[5] = 0 one cycle later.
- Two accepted writers to `rd`=7 (IDs 0 and 1); return ID 0 → sb[7] stays 1. Return ID 1 → sb[7] clears.
- Fill `X_MAX_OUTSTANDING` = 4 entries → fifth writeback instruction: `x_valid_o` = 0 and `x_stall_o` = 1. One retire → issue resumes next cycle.
- Reject (`x_accept_i` = 0) → `x_illegal_insn_o` = 1, `id_q` unchanged, no entry allocated.
- Three mem-op accepts, then core `lw` (`x_data_req_dec_i` = 1) → stall until `xmem_valid_i` has pulsed three times and `mem_cnt_q` = 0. Same-cycle mem-op accept plus `xmem_valid_i` → counter unchanged.
- Result with an unknown `x_rid_i` → table unchanged. Assert `rst_ni` low with entries live → all sb bits 0 immediately.
